// File: rtl/halmem_bus_writer_pkg.sv
// Shared definitions for the HALMEM command FIFO entry format and the bus writer.
// The FIFO producer builds entries with the helpers below so both sides agree on the layout.
package halmem_bus_writer_pkg;

  typedef enum logic [1:0] {
    KIND_IO   = 2'b00,
    KIND_MEM  = 2'b01,
    KIND_WAIT = 2'b10,
    KIND_RSVD = 2'b11
  } entry_kind_e;

  localparam int unsigned ENTRY_W   = 24;
  localparam int unsigned KIND_MSB  = 23;
  localparam int unsigned KIND_LSB  = 22;
  localparam int unsigned MADDR_MSB = 21;
  localparam int unsigned MADDR_LSB = 8;
  localparam int unsigned PORT_MSB  = 15;
  localparam int unsigned PORT_LSB  = 8;
  localparam int unsigned DATA_MSB  = 7;
  localparam int unsigned DATA_LSB  = 0;
  localparam int unsigned WCNT_MSB  = 15;
  localparam int unsigned WCNT_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER,
    ST_WAIT
  } wr_state_e;

  function automatic entry_kind_e entry_kind(input logic [ENTRY_W-1:0] e);
    return entry_kind_e'(e[KIND_MSB:KIND_LSB]);
  endfunction

  function automatic logic [ENTRY_W-1:0] make_io_entry(input logic [7:0] port,
                                                        input logic [7:0] data);
    return {KIND_IO, 6'b000000, port, data};
  endfunction

  function automatic logic [ENTRY_W-1:0] make_mem_entry(input logic [13:0] addr,
                                                         input logic [7:0]  data);
    return {KIND_MEM, addr, data};
  endfunction

  function automatic logic [ENTRY_W-1:0] make_wait_entry(input logic [15:0] ticks);
    return {KIND_WAIT, 6'b000000, ticks};
  endfunction

endpackage

// File: rtl/halmem_cycle_counter.sv
// Loadable 16-bit down-counter with decrement enable and zero flag.
// Load has priority over decrement; decrement saturates at zero.
module halmem_cycle_counter (
  input  logic        i_CLK,
  input  logic        i_RST_n,
  input  logic        i_LOAD,
  input  logic [15:0] i_LOAD_VAL,
  input  logic        i_DEC,
  output logic        o_ZERO
);

  logic [15:0] count;

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      count <= '0;
    end else if (i_LOAD) begin
      count <= i_LOAD_VAL;
    end else if (i_DEC && (count != '0)) begin
      count <= count - 16'd1;
    end
  end

  assign o_ZERO = (count == '0);

endmodule

// File: rtl/halmem_bus_writer.sv
// Pops HALMEM command entries and replays them as MSX-style I/O or memory write cycles,
// with programmable strobe width, post-write recovery and tick-based waits.
module halmem_bus_writer
  import halmem_bus_writer_pkg::*;
#(
  parameter int unsigned WR_CYCLES       = 4,
  parameter int unsigned RECOVERY_CYCLES = 24,
  parameter logic [1:0]  MEM_BASE_HI     = 2'b10
) (
  input  logic        i_CLK,
  input  logic        i_RST_n,
  input  logic        i_ENABLE,
  input  logic        i_EMPTY,
  output logic        o_POP_S,
  input  logic [23:0] i_POP_DT,
  input  logic        i_TICK,
  input  logic        i_BUS_BUSY,
  output logic [15:0] o_ADDR,
  output logic [7:0]  o_DATA,
  output logic        o_IORQ_n,
  output logic        o_MREQ_n,
  output logic        o_WR_n,
  output logic        o_BUSY
);

  // The counter is loaded with N-1 and phases end on the zero flag, giving exactly N cycles.
  localparam logic [15:0] STROBE_LOAD  = 16'(WR_CYCLES - 1);
  localparam logic [15:0] RECOVER_LOAD = (RECOVERY_CYCLES == 0) ? 16'd0
                                                                : 16'(RECOVERY_CYCLES - 1);
  localparam logic        HAS_RECOVERY = (RECOVERY_CYCLES != 0);

  wr_state_e   state;
  entry_kind_e kind;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;
  logic [15:0] cnt_val;

  assign kind = entry_kind(i_POP_DT);

  halmem_cycle_counter u_cycle_counter (
    .i_CLK      (i_CLK),
    .i_RST_n    (i_RST_n),
    .i_LOAD     (cnt_load),
    .i_LOAD_VAL (cnt_val),
    .i_DEC      (cnt_dec),
    .o_ZERO     (cnt_zero)
  );

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state)
      ST_LOAD: begin
        // Loading here also masks any tick coincident with the LOAD cycle.
        cnt_load = 1'b1;
        cnt_val  = i_POP_DT[WCNT_MSB:WCNT_LSB] - 16'd1;
      end
      ST_SETUP: begin
        if (!i_BUS_BUSY) begin
          cnt_load = 1'b1;
          cnt_val  = STROBE_LOAD;
        end
      end
      ST_STROBE:  cnt_dec = 1'b1;
      ST_HOLD: begin
        cnt_load = 1'b1;
        cnt_val  = RECOVER_LOAD;
      end
      ST_RECOVER: cnt_dec = 1'b1;
      ST_WAIT:    cnt_dec = i_TICK;
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      state    <= ST_IDLE;
      o_POP_S  <= 1'b0;
      o_ADDR   <= '0;
      o_DATA   <= '0;
      o_IORQ_n <= 1'b1;
      o_MREQ_n <= 1'b1;
      o_WR_n   <= 1'b1;
      o_BUSY   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_ENABLE && !i_EMPTY) begin
            state   <= ST_POP;
            o_POP_S <= 1'b1;
            o_BUSY  <= 1'b1;
          end
        end

        ST_POP: begin
          o_POP_S <= 1'b0;
          state   <= ST_LOAD;
        end

        ST_LOAD: begin
          case (kind)
            KIND_IO: begin
              o_ADDR   <= {8'h00, i_POP_DT[PORT_MSB:PORT_LSB]};
              o_DATA   <= i_POP_DT[DATA_MSB:DATA_LSB];
              o_IORQ_n <= 1'b0;
              state    <= ST_SETUP;
            end
            KIND_MEM: begin
              o_ADDR   <= {MEM_BASE_HI, i_POP_DT[MADDR_MSB:MADDR_LSB]};
              o_DATA   <= i_POP_DT[DATA_MSB:DATA_LSB];
              o_MREQ_n <= 1'b0;
              state    <= ST_SETUP;
            end
            KIND_WAIT: begin
              if (i_POP_DT[WCNT_MSB:WCNT_LSB] != '0) begin
                state <= ST_WAIT;
              end else begin
                state  <= ST_IDLE;
                o_BUSY <= 1'b0;
              end
            end
            default: begin
              state  <= ST_IDLE;
              o_BUSY <= 1'b0;
            end
          endcase
        end

        ST_SETUP: begin
          if (!i_BUS_BUSY) begin
            o_WR_n <= 1'b0;
            state  <= ST_STROBE;
          end
        end

        ST_STROBE: begin
          if (cnt_zero) begin
            o_WR_n <= 1'b1;
            state  <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          o_IORQ_n <= 1'b1;
          o_MREQ_n <= 1'b1;
          if (HAS_RECOVERY) begin
            state <= ST_RECOVER;
          end else begin
            state  <= ST_IDLE;
            o_BUSY <= 1'b0;
          end
        end

        ST_RECOVER: begin
          if (cnt_zero) begin
            state  <= ST_IDLE;
            o_BUSY <= 1'b0;
          end
        end

        ST_WAIT: begin
          // Counter holds remaining-1, so a tick seen at zero is the final one.
          if (!i_ENABLE || (i_TICK && cnt_zero)) begin
            state  <= ST_IDLE;
            o_BUSY <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          o_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_halmem_bus_writer.sv
// Randomised scoreboard bench for halmem_bus_writer with a cycle-level reference model.
`timescale 1ns/1ps
module tb_halmem_bus_writer;

  localparam int unsigned WR  = 4;
  localparam int unsigned REC = 24;

  logic        i_CLK      = 1'b0;
  logic        i_RST_n    = 1'b0;
  logic        i_ENABLE   = 1'b0;
  logic        i_EMPTY    = 1'b1;
  logic [23:0] i_POP_DT   = '0;
  logic        i_TICK     = 1'b0;
  logic        i_BUS_BUSY = 1'b0;
  logic        o_POP_S;
  logic [15:0] o_ADDR;
  logic [7:0]  o_DATA;
  logic        o_IORQ_n;
  logic        o_MREQ_n;
  logic        o_WR_n;
  logic        o_BUSY;

  halmem_bus_writer #(
    .WR_CYCLES       (WR),
    .RECOVERY_CYCLES (REC),
    .MEM_BASE_HI     (2'b10)
  ) dut (
    .i_CLK      (i_CLK),
    .i_RST_n    (i_RST_n),
    .i_ENABLE   (i_ENABLE),
    .i_EMPTY    (i_EMPTY),
    .o_POP_S    (o_POP_S),
    .i_POP_DT   (i_POP_DT),
    .i_TICK     (i_TICK),
    .i_BUS_BUSY (i_BUS_BUSY),
    .o_ADDR     (o_ADDR),
    .o_DATA     (o_DATA),
    .o_IORQ_n   (o_IORQ_n),
    .o_MREQ_n   (o_MREQ_n),
    .o_WR_n     (o_WR_n),
    .o_BUSY     (o_BUSY)
  );

  always #5 i_CLK = ~i_CLK;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        mem;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [23:0] fifo_q[$];
  logic [23:0] ent_q[$];
  wr_t         exp_q[$];

  int   tick_mode  = 0;
  int   tick_phase = 0;
  int   busy_mode  = 0;
  logic busy_force = 1'b0;

  task automatic push_entry(input logic [23:0] e);
    wr_t w;
    fifo_q.push_back(e);
    ent_q.push_back(e);
    if (e[23] == 1'b0) begin
      w.mem  = e[22];
      w.addr = e[22] ? {2'b10, e[21:8]} : {8'h00, e[15:8]};
      w.data = e[7:0];
      exp_q.push_back(w);
    end
  endtask

  // FIFO model plus tick and bus-busy generators, all driven on the falling edge.
  initial forever begin
    @(negedge i_CLK);
    if (o_POP_S) begin
      tests++;
      if (fifo_q.size() == 0) begin
        fails++;
        $display("FAIL pop_underflow: o_POP_S=1 with FIFO empty, required no pop");
      end else begin
        i_POP_DT = fifo_q.pop_front();
      end
    end
    i_EMPTY = (fifo_q.size() == 0);
    case (tick_mode)
      1: begin
        tick_phase = (tick_phase + 1) % 10;
        i_TICK = (tick_phase == 0);
      end
      2:       i_TICK = ($urandom_range(0, 3) == 0);
      default: i_TICK = 1'b0;
    endcase
    i_BUS_BUSY = (busy_mode != 0) ? ($urandom_range(0, 3) == 0) : busy_force;
  end

  // Reference model: walks the write-cycle phases and predicts every output each cycle.
  typedef enum {M_IDLE, M_POP, M_LOAD, M_SETUP, M_STROBE, M_HOLD, M_REC, M_WAIT} mph_e;
  mph_e        m = M_IDLE;
  logic [23:0] cur = 24'hC00000;
  int          str_left = 0;
  int          rec_left = 0;
  int          wait_left = 0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  logic        m_mem = 1'b0;
  logic        prev_wr = 1'b1;

  initial forever begin
    logic       req;
    logic [4:0] got_ctl;
    logic [4:0] want_ctl;
    wr_t        w;
    string      nm;
    @(posedge i_CLK);
    #1;
    if (!i_RST_n) begin
      if ((m == M_POP || m == M_LOAD || m == M_SETUP) && cur[23] == 1'b0 && exp_q.size() > 0)
        exp_q.delete(0);
      m      = M_IDLE;
      m_addr = '0;
      m_data = '0;
      nm     = "reset_state";
    end else begin
      nm = "cycle";
      case (m)
        M_IDLE: begin
          if (i_ENABLE && !i_EMPTY) begin
            m   = M_POP;
            cur = (ent_q.size() > 0) ? ent_q.pop_front() : 24'hC00000;
          end
        end
        M_POP: m = M_LOAD;
        M_LOAD: begin
          case (cur[23:22])
            2'b00: begin
              m = M_SETUP; m_mem = 1'b0;
              m_addr = {8'h00, cur[15:8]}; m_data = cur[7:0];
            end
            2'b01: begin
              m = M_SETUP; m_mem = 1'b1;
              m_addr = {2'b10, cur[21:8]}; m_data = cur[7:0];
            end
            2'b10: begin
              wait_left = int'(cur[15:0]);
              m = (wait_left != 0) ? M_WAIT : M_IDLE;
            end
            default: m = M_IDLE;
          endcase
        end
        M_SETUP: begin
          if (!i_BUS_BUSY) begin
            m = M_STROBE;
            str_left = WR;
          end
        end
        M_STROBE: begin
          str_left--;
          if (str_left == 0) m = M_HOLD;
        end
        M_HOLD: begin
          if (REC == 0) m = M_IDLE;
          else begin
            m = M_REC;
            rec_left = REC;
          end
        end
        M_REC: begin
          rec_left--;
          if (rec_left == 0) m = M_IDLE;
        end
        M_WAIT: begin
          if (!i_ENABLE) m = M_IDLE;
          else if (i_TICK) begin
            wait_left--;
            if (wait_left == 0) m = M_IDLE;
          end
        end
        default: m = M_IDLE;
      endcase
    end

    req      = (m == M_SETUP || m == M_STROBE || m == M_HOLD);
    want_ctl = {m == M_POP, m != M_IDLE, !(req && !m_mem), !(req && m_mem), m != M_STROBE};
    got_ctl  = {o_POP_S, o_BUSY, o_IORQ_n, o_MREQ_n, o_WR_n};
    tests++;
    if (got_ctl !== want_ctl || o_ADDR !== m_addr || o_DATA !== m_data) begin
      fails++;
      $display("FAIL %s t=%0t: pop,busy,iorq_n,mreq_n,wr_n/addr/data got %b/%h/%h required %b/%h/%h",
               nm, $time, got_ctl, o_ADDR, o_DATA, want_ctl, m_addr, m_data);
    end

    // Scoreboard: each write strobe must match the next expected transaction.
    if (i_RST_n && prev_wr && !o_WR_n) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", o_ADDR, o_DATA);
      end else begin
        w = exp_q.pop_front();
        if ({o_IORQ_n, o_MREQ_n, o_ADDR, o_DATA} !== {w.mem, !w.mem, w.addr, w.data}) begin
          fails++;
          $display("FAIL write_txn: iorq_n=%b mreq_n=%b addr=%h data=%h required %b %b %h %h",
                   o_IORQ_n, o_MREQ_n, o_ADDR, o_DATA, w.mem, !w.mem, w.addr, w.data);
        end
      end
    end
    prev_wr = o_WR_n;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge i_CLK);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((fifo_q.size() != 0 || o_BUSY) && k < budget) begin
      @(negedge i_CLK);
      k++;
    end
    cyc(2);
    tests++;
    if (k >= budget) begin
      fails++;
      $display("FAIL timeout_%s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic wait_for(input string name, input int which, input int budget);
    int   k;
    logic hit;
    k   = 0;
    hit = 1'b0;
    while (!hit && k < budget) begin
      @(negedge i_CLK);
      k++;
      case (which)
        0:       hit = !o_WR_n;
        1:       hit = !o_IORQ_n;
        default: hit = o_BUSY;
      endcase
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL timeout_%s: condition not seen in %0d cycles", name, budget);
    end
  endtask

  initial begin
    logic [23:0] e;
    int unsigned r;
    i_RST_n = 1'b0;
    cyc(3);
    i_RST_n  = 1'b1;
    i_ENABLE = 1'b1;

    push_entry(24'h00A05A);
    wait_idle("io_basic", 200);
    push_entry(24'h58803F);
    wait_idle("mem_basic", 200);

    tick_mode = 1;
    push_entry(24'h800003);
    push_entry(24'h007C12);
    wait_idle("wait3", 400);
    push_entry(24'h800000);
    wait_idle("wait0", 100);

    busy_force = 1'b1;
    push_entry(24'h003311);
    wait_for("busy_setup", 1, 60);
    cyc(6);
    busy_force = 1'b0;
    wait_idle("busy_stall", 200);

    cyc(20);

    push_entry(24'h800100);
    wait_for("wait_start", 2, 30);
    cyc(5);
    i_ENABLE = 1'b0;
    push_entry(24'h004455);
    cyc(15);
    i_ENABLE = 1'b1;
    wait_idle("wait_abort", 200);

    push_entry(24'h4123AB);
    wait_for("strobe_en", 0, 60);
    i_ENABLE = 1'b0;
    wait_idle("strobe_disable", 200);
    i_ENABLE = 1'b1;

    push_entry(24'h00B0C3);
    wait_for("strobe_rst", 0, 60);
    cyc(1);
    i_RST_n = 1'b0;
    cyc(1);
    i_RST_n = 1'b1;
    wait_idle("after_reset", 200);

    push_entry(24'hC00000);
    push_entry(24'h001122);
    wait_idle("reserved", 200);

    tick_mode = 2;
    busy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      e = 24'($urandom);
      if (r < 4)      e[23:22] = 2'b00;
      else if (r < 7) e[23:22] = 2'b01;
      else if (r < 9) begin
        e[23:22] = 2'b10;
        e[15:0]  = 16'($urandom_range(0, 5));
      end else        e[23:22] = 2'b11;
      push_entry(e);
      i_ENABLE = ($urandom_range(0, 7) != 0);
      cyc($urandom_range(0, 40));
    end
    i_ENABLE = 1'b1;
    wait_idle("random_drain", 20000);

    tests++;
    if (exp_q.size() != 0 || ent_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: %0d writes %0d entries pending, required 0 0",
               exp_q.size(), ent_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/halmem_bus_writer.md
Name: halmem_bus_writer

Overview:
- Downstream consumer of the HALMEM 24-bit command FIFO.
- Pops one entry at a time and decodes it as a sound-chip I/O write, a memory-window write, or a tick-based wait.
- Drives an MSX-style write cycle with configurable strobe width and post-write recovery time, so back-to-back register writes obey chip (OPLL/PSG/SCC) timing.
- Sits between the FIFO and the cartridge/sound-chip bus pins.

Parameters:
- WR_CYCLES, 4, clocks o_WR_n is held low (1..255).
- RECOVERY_CYCLES, 24, idle clocks after each write before the next pop (0..65535; 0 = no recovery).
- MEM_BASE_HI, 2'b10, top two address bits for memory writes (window 0x8000-0xBFFF).

Ports:
- i_CLK  in  1  system clock
- i_RST_n  in  1  reset
- i_ENABLE  in  1  playback enable; sampled in IDLE, aborts WAIT
- i_EMPTY  in  1  FIFO empty flag
- o_POP_S  out  1  FIFO pop strobe
- i_POP_DT  in  24  FIFO read data, valid the cycle after o_POP_S
- i_TICK  in  1  one-clock timebase pulse for wait commands
- i_BUS_BUSY  in  1  bus owned elsewhere; stalls cycle start
- o_ADDR  out  16  bus address
- o_DATA  out  8  bus write data
- o_IORQ_n  out  1  I/O request, active low
- o_MREQ_n  out  1  memory request, active low
- o_WR_n  out  1  write strobe, active low
- o_BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset: i_RST_n is synchronous and active-low; clock is i_CLK.
- Reset values: o_POP_S=0, o_ADDR=0, o_DATA=0, o_IORQ_n=1, o_MREQ_n=1, o_WR_n=1, o_BUSY=0, state=IDLE.
- Reset mid-cycle: reset applies at the next edge regardless of state. Strobes release immediately and the partially executed entry is discarded.
- All outputs are registered.
- Entry format:
  - [23:22]=00 IO write: port=[15:8], data=[7:0].
  - 01 MEM write: addr={MEM_BASE_HI,[21:8]}, data=[7:0].
  - 10 WAIT: count=[15:0] ticks.
  - 11 reserved: dropped, no bus activity.
- IDLE: if i_ENABLE && !i_EMPTY, go to POP. Otherwise stay.
- POP: o_POP_S=1 for exactly this one cycle, then go to LOAD. o_POP_S is never high when i_EMPTY was high in the preceding IDLE cycle.
- LOAD: capture i_POP_DT and decode.
  - IO/MEM go to SETUP.
  - WAIT with count!=0 goes to WAIT; count==0 goes to IDLE.
  - Reserved goes to IDLE.
- SETUP: o_ADDR/o_DATA driven, o_IORQ_n or o_MREQ_n low per kind, o_WR_n=1.
  - Stays in SETUP while i_BUS_BUSY=1 (minimum 1 cycle), then goes to STROBE.
- STROBE: o_WR_n=0 for exactly WR_CYCLES clocks. i_BUS_BUSY is ignored once here.
- HOLD: 1 cycle, o_WR_n=1, request still low, addr/data held.
- RECOVER: request high. o_ADDR/o_DATA keep their last values.
  - Counts RECOVERY_CYCLES clocks, then goes to IDLE. Skipped if the value is 0 (HOLD goes straight to IDLE).
- WAIT: 16-bit down-counter loaded in LOAD, decremented on each i_TICK.
  - Goes to IDLE on the tick that takes it from 1 to 0.
  - A tick coincident with the LOAD cycle is not counted.
  - If i_ENABLE=0 in any WAIT cycle, go to IDLE immediately; the remaining count is dropped.
- i_ENABLE has no effect on POP/LOAD/SETUP/STROBE/HOLD/RECOVER. A started write always completes.
- Write-entry latency with no stall: IDLE→first o_WR_n low = 4 clocks (IDLE, POP, LOAD, SETUP).
- Write-entry period: 5+WR_CYCLES+RECOVERY_CYCLES clocks.
- Only one request line is low at a time. Both are high outside SETUP/STROBE/HOLD.

Decomposition:
- Shared package:
  - entry-kind constants (KIND_IO, KIND_MEM, KIND_WAIT, KIND_RSVD);
  - bit-field positions of the 24-bit entry;
  - state encoding.
- The FIFO producer uses the same package to build entries.
- One natural sub-module: halmem_cycle_counter, a loadable 16-bit down-counter with enable and zero flag. It is shared by STROBE, RECOVER and WAIT.

Test Plan:
- Push 0x00A0_5A with RECOVERY_CYCLES=24 and WR_CYCLES=4 → o_POP_S one cycle; o_ADDR=0x00A0, o_DATA=0x5A, o_IORQ_n low 6 clocks, o_WR_n low exactly 4 clocks; next pop ≥24 clocks after HOLD.
- Push 0x5880_3F → o_MREQ_n low, o_ADDR=0x9880, o_DATA=0x3F, o_IORQ_n stays 1.
- Push WAIT 0x80_0003 then IO 0x007C_12; pulse i_TICK every 10 clocks → IO write SETUP starts 3 ticks after LOAD. WAIT 0x80_0000 → returns to IDLE with no wait.
- Hold i_BUS_BUSY=1 for 7 clocks during SETUP → o_WR_n remains high until busy drops, then low for 4.
- FIFO empty with i_ENABLE=1 → o_POP_S never asserted. Deassert i_ENABLE mid-WAIT → IDLE next clock, no further pops. Deassert mid-STROBE → write completes.
- Assert i_RST_n=0 during STROBE → next edge o_WR_n=1, o_IORQ_n=1, o_BUSY=0. Reserved entry 0xC0_0000 → no bus activity.
